systolic_output_drain: RTL
==========================

# systolic_output_drain

Drains finished accumulator results out of the systolic PE array one row at a time once the systolic controller signals a completed tile. Each lane is requantized by rounding, arithmetic right shift and saturation to signed 8-bit. Each packed row is written to output memory under ready/valid backpressure. When the last row is accepted, the block pulses `clr` so the array can start the next tile.

## Interface
- `ARRAY_SIZE`, 16, PE rows/columns; one output word per row
- `ACC_WIDTH`, 24, signed accumulator width per PE
- `DATA_WIDTH`, 8, signed output element width
- `ADDR_WIDTH`, 8, output memory address width

- `clk` in 1: sole clock
- `rst_n` in 1: reset, synchronous, active-low
- `drain_start` in 1: one-cycle pulse from controller; PE accumulators hold valid results
- `shift` in 4: requant right-shift amount (0..15), sampled on accepted `drain_start`
- `base_addr` in ADDR_WIDTH: first output address, sampled on accepted `drain_start`
- `acc_in` in ARRAY_SIZE*ACC_WIDTH: packed signed accumulators of the row selected by `row_sel`; lane 0 in LSBs
- `row_sel` out $clog2(ARRAY_SIZE): PE row currently read
- `wr_en` out 1: output write valid
- `wr_addr` out ADDR_WIDTH: output write address
- `wr_data` out ARRAY_SIZE*DATA_WIDTH: packed requantized row; lane 0 in LSBs
- `wr_ready` in 1: memory accepts the write this cycle
- `clr` out 1: one-cycle pulse, clears PE accumulators
- `busy` out 1: drain in progress
- `done` out 1: one-cycle pulse, drain complete

## Operation
- States: IDLE, FETCH, WRITE, CLEAR.
- IDLE:
  - On `drain_start`, latch `shift` and `base_addr`.
  - Set row counter to 0 and address to `base_addr`.
  - Go to FETCH.
- FETCH:
  - `row_sel` = row counter.
  - Register `acc_in` through the requant lanes into `wr_data`.
  - Go to WRITE.
- WRITE:
  - `wr_en`=1; `wr_addr` and `wr_data` are held stable until `wr_ready`=1.
  - On accept, increment address and row counter.
  - Last row (ARRAY_SIZE-1) goes to CLEAR; otherwise go to FETCH.
- CLEAR:
  - `clr`=1 and `done`=1 for exactly one cycle.
  - Return to IDLE.
- Requant, per lane, signed arithmetic:
  - Compute `t = acc + (shift>0 ? 1<<(shift-1) : 0)` at ACC_WIDTH+1 bits, so there is no overflow.
  - Compute `r = t >>> shift`.
  - Saturate `r` to [-128, 127].
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- `drain_start` while `busy` is ignored; no queuing.
- `wr_ready` outside WRITE is ignored.
- Reset, including mid-drain:
  - State returns to IDLE on the next edge.
  - `wr_en`, `clr`, `done`, `busy` = 0; `row_sel`, `wr_addr`, `wr_data` = 0.
  - No `clr` is issued for an aborted drain.

## Timing
- `drain_start` sampled at edge T; FETCH occupies cycle T+1 with `row_sel`=0.
- WRITE begins at T+2 with `wr_en`=1 and row 0 data.
- Minimum 2 cycles per row, so CLEAR is no earlier than T+1+2*ARRAY_SIZE.
- Each stalled cycle (`wr_ready`=0) adds exactly one cycle.
- `busy`=1 from T+1 through the CLEAR cycle inclusive; 0 in IDLE.
- `acc_in` must be valid combinationally in the same cycle `row_sel` is driven; it is registered at the end of FETCH.
- All outputs are registered or decoded from registered state; there is no combinational path from `wr_ready` to `wr_data`/`wr_addr`.

## Configuration
- `DRAIN_RELU_EN`:
  - Defined: each lane clamps negative saturated results to 0 before packing, giving an output range [0, 127].
  - Undefined: signed output range [-128, 127].
- The macro does not affect latency or the interface.

## Structure
- Package `systolic_pkg`:
  - `drain_state_t` enum (IDLE, FETCH, WRITE, CLEAR)
  - `SAT_MAX`=127 and `SAT_MIN`=-128 constants
  - shared `ARRAY_SIZE`/width defaults
- Sub-module `requant_lane`:
  - combinational round, shift, saturate, and optional ReLU for one lane
  - instantiated ARRAY_SIZE times via generate
- The FSM, counters and output registers live in the top.

## Test plan
Bench uses ARRAY_SIZE=4.
- Reset then idle, `wr_ready`=1, all lanes 1000, shift=3, base_addr=0x10 → four writes to 0x10..0x13 with every lane 125; `clr` and `done` pulse once at T+9.
- Lanes {1100, -1000, 5, -5}, shift=3, macro undefined → {127, -125, 1, -1}.
- Same stimulus with `DRAIN_RELU_EN` defined → {127, 0, 1, 0}.
- shift=0, lanes {127, 128, -129, 0} → {127, 127, -128, 0}.
- base_addr=0xFE, `wr_ready` low for 3 cycles on row 1:
  - addresses are 0xFE, 0xFF, 0x00, 0x01
  - `wr_addr`/`wr_data` hold during the stall
  - completion occurs 3 cycles later
- `drain_start` during WRITE is ignored; `rst_n`=0 asserted in row 2 WRITE → next cycle all outputs 0, no `clr`; a new `drain_start` then runs a full drain.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic output drain path.
package systolic_pkg;

  localparam int unsigned DEF_ARRAY_SIZE = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 24;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned SHIFT_WIDTH    = 4;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    CLEAR
  } drain_state_t;

endpackage

// File: rtl/systolic_output_drain_requant_lane.sv
// Single-lane requantizer: round-half-up, arithmetic right shift, saturate to int8.
// Optional ReLU clamp when DRAIN_RELU_EN is defined.
module requant_lane
  import systolic_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic        [DATA_WIDTH-1:0]  q
);

  localparam logic signed [ACC_WIDTH:0] HI = (ACC_WIDTH+1)'(SAT_MAX);
  localparam logic signed [ACC_WIDTH:0] LO = (ACC_WIDTH+1)'(SAT_MIN);

  logic        [ACC_WIDTH:0]  rnd;
  logic signed [ACC_WIDTH:0]  t;
  logic signed [ACC_WIDTH:0]  r;
  logic signed [DATA_WIDTH-1:0] sat;

  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = (ACC_WIDTH+1)'(1) << (shift - 1'b1);
    end
    // One guard bit keeps the rounding add from overflowing.
    t = $signed({acc[ACC_WIDTH-1], acc}) + $signed(rnd);
    r = t >>> shift;

    if (r > HI) begin
      sat = DATA_WIDTH'(SAT_MAX);
    end else if (r < LO) begin
      sat = DATA_WIDTH'(SAT_MIN);
    end else begin
      sat = r[DATA_WIDTH-1:0];
    end

`ifdef DRAIN_RELU_EN
    if (sat[DATA_WIDTH-1]) begin
      sat = '0;
    end
`else
`endif

    q = sat;
  end

endmodule

// File: rtl/systolic_output_drain.sv
// Drains PE accumulator rows through requant lanes into output memory, then clears the array.
// Build option: DRAIN_RELU_EN (passed through to requant_lane) clamps negative outputs to 0.
module systolic_output_drain
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             drain_start,
  input  logic [SHIFT_WIDTH-1:0]           shift,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  acc_in,
  output logic [$clog2(ARRAY_SIZE)-1:0]    row_sel,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
  input  logic                             wr_ready,
  output logic                             clr,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned ROW_W = $clog2(ARRAY_SIZE);

  drain_state_t state;
  drain_state_t state_n;

  logic [SHIFT_WIDTH-1:0]           shift_q;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [ROW_W-1:0]                 row_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] lane_q;

  logic start_ok;
  logic accept;
  logic last_row;

  assign start_ok = (state == IDLE) && drain_start;
  assign accept   = (state == WRITE) && wr_ready;
  assign last_row = (row_q == ROW_W'(ARRAY_SIZE - 1));

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    requant_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .acc   (acc_in[i*ACC_WIDTH +: ACC_WIDTH]),
      .shift (shift_q),
      .q     (lane_q[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    clr     = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (drain_start) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        state_n = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) begin
          state_n = last_row ? CLEAR : FETCH;
        end
      end
      CLEAR: begin
        clr     = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Address and data only move on accept, so a stalled write holds steady.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
    end else begin
      if (start_ok) begin
        shift_q <= shift;
        addr_q  <= base_addr;
        row_q   <= '0;
      end
      if (state == FETCH) begin
        data_q <= lane_q;
      end
      if (accept) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        row_q  <= row_q + ROW_W'(1);
      end
    end
  end

  assign row_sel = row_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule
